// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron trainer.
// State encoding, target encoding and accumulator sizing.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CALC,
        UPDATE,
        DONE
    } state_t;

    // Target bit 1 carries the sign: 0 means +1, 1 means -1.
    localparam int         T_SIGN = 1;
    localparam logic [1:0] T_POS  = 2'b00;
    localparam logic [1:0] T_NEG  = 2'b10;

    // Wide enough for bias plus N_IN full-scale products.
    function automatic int acc_width(
        input int w_w,
        input int x_w,
        input int n_in
    );
        return w_w + x_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Multiply-accumulate for the trainer: loads the bias on clear,
// then adds one weight*input product per enabled cycle.
module perceptron_mac
    import perceptron_pkg::*;
#(
    parameter int X_W = 7,
    parameter int W_W = 14,
    parameter int A_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic signed [W_W-1:0] init,
    input  logic signed [W_W-1:0] wi,
    input  logic signed [X_W-1:0] xi,
    output logic signed [A_W-1:0] acc
);

    logic signed [W_W+X_W-1:0] prod;

    assign prod = wi * xi;

    // Accumulator register: clear loads the bias, enable adds a product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= A_W'(init);
        end else if (en) begin
            acc <= acc + A_W'(prod);
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: fetches samples, predicts, updates weights.
// Define PERCEPTRON_SAT_EN to saturate updates instead of wrapping.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int X_W       = 7,
    parameter int W_W       = 14,
    parameter int MAX_EPOCH = 16,
    parameter int LR_SHIFT  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            n_samples,
    input  logic [N_IN*X_W-1:0]    x,
    input  logic [1:0]             t,
    input  logic                   data_ready,
    output logic                   request,
    output logic                   done,
    output logic                   converged,
    output logic [N_IN*W_W-1:0]    w,
    output logic signed [W_W-1:0]  b,
    output logic [31:0]            epoch
);

    localparam int A_W  = acc_width(W_W, X_W, N_IN);
    localparam int CH_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int S_W  = W_W + X_W + LR_SHIFT + 2;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_IN - 1);

    state_t state, state_nx;

    logic signed [W_W-1:0] wr [N_IN];
    logic signed [X_W-1:0] xr [N_IN];
    logic signed [S_W-1:0] wdel [N_IN];
    logic signed [S_W-1:0] wsum [N_IN];
    logic signed [S_W-1:0] bdel, bsum;
    logic signed [A_W-1:0] acc;
    logic [31:0]           n_lat, idx;
    logic [CH_W-1:0]       ch;
    logic                  t_neg, err;
    logic                  capture, mismatch, err_any;
    logic                  last_smp, cap_hit;
    logic                  t_unused;

    assign t_unused = t[0];
    assign capture  = (state == REQ) && data_ready;
    assign mismatch = (acc < A_W'(0)) != t_neg;
    assign err_any  = err | mismatch;
    assign last_smp = (idx + 32'd1) >= n_lat;
    assign cap_hit  = (epoch + 32'd1) >= 32'(MAX_EPOCH);
    assign request  = (state == REQ);
    assign done     = (state == DONE);

    for (genvar i = 0; i < N_IN; i++) begin : g_pack
        assign w[i*W_W +: W_W] = wr[i];
    end

`ifdef PERCEPTRON_SAT_EN
    localparam logic signed [S_W-1:0] W_MAX = S_W'((2 ** (W_W - 1)) - 1);
    localparam logic signed [S_W-1:0] W_MIN = S_W'(-(2 ** (W_W - 1)));
`endif

    // Bring a widened update result back into W_W bits.
    function automatic logic signed [W_W-1:0] fit(
        input logic signed [S_W-1:0] v
    );
`ifdef PERCEPTRON_SAT_EN
        if (v > W_MAX) return W_MAX[W_W-1:0];
        if (v < W_MIN) return W_MIN[W_W-1:0];
`endif
        return v[W_W-1:0];
    endfunction

    perceptron_mac #(
        .X_W (X_W),
        .W_W (W_W),
        .A_W (A_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .en   (state == CALC),
        .init (b),
        .wi   (wr[ch]),
        .xi   (xr[ch]),
        .acc  (acc)
    );

    // Candidate weights and bias moved by +/- x (or 1) scaled by the rate.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            wdel[i] = S_W'(xr[i]) <<< LR_SHIFT;
            if (t_neg) wdel[i] = -wdel[i];
            wsum[i] = S_W'(wr[i]) + wdel[i];
        end
        bdel = S_W'(1) <<< LR_SHIFT;
        if (t_neg) bdel = -bdel;
        bsum = S_W'(b) + bdel;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (n_samples == '0) ? DONE : REQ;
            end
            REQ: begin
                if (data_ready) state_nx = CALC;
            end
            CALC: begin
                if (ch == CH_LAST) state_nx = UPDATE;
            end
            UPDATE: begin
                if (!last_smp)                state_nx = REQ;
                else if (!err_any || cap_hit) state_nx = DONE;
                else                          state_nx = REQ;
            end
            DONE: begin
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Training datapath: sample capture, channel walk, weight update, epochs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) begin
                wr[i] <= '0;
                xr[i] <= '0;
            end
            b         <= '0;
            epoch     <= '0;
            converged <= 1'b0;
            t_neg     <= 1'b0;
            n_lat     <= '0;
            idx       <= '0;
            err       <= 1'b0;
            ch        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_IN; i++) wr[i] <= '0;
                        b         <= '0;
                        epoch     <= '0;
                        idx       <= '0;
                        err       <= 1'b0;
                        n_lat     <= n_samples;
                        converged <= (n_samples == '0);
                    end
                end
                REQ: begin
                    if (data_ready) begin
                        for (int i = 0; i < N_IN; i++) begin
                            xr[i] <= x[i*X_W +: X_W];
                        end
                        t_neg <= t[T_SIGN];
                        ch    <= '0;
                    end
                end
                CALC: begin
                    ch <= ch + CH_W'(1);
                end
                UPDATE: begin
                    if (mismatch) begin
                        for (int i = 0; i < N_IN; i++) wr[i] <= fit(wsum[i]);
                        b <= fit(bsum);
                    end
                    idx <= idx + 32'd1;
                    if (!last_smp) begin
                        err <= err_any;
                    end else begin
                        epoch <= epoch + 32'd1;
                        if (!err_any) begin
                            converged <= 1'b1;
                        end else if (!cap_hit) begin
                            idx <= '0;
                            err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
